// File: rtl/ictrl_ibuffer_load_sched.sv
// Loads a program image into the ibuffer as ping-pong bank chunks: one DMA read
// command per chunk, then the filled bank is handed to the fetch unit.
module ictrl_ibuffer_load_sched #(
  parameter int MEM_AW     = 15,
  parameter int DDR_AW     = 32,
  parameter int LEN_W      = 20,
  parameter int BANK_DEPTH = 256,
  parameter int BEAT_BYTES = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cfg_start,
  input  logic [DDR_AW-1:0]      cfg_base_addr,
  input  logic [LEN_W-1:0]       cfg_total_beats,
  input  logic                   cfg_abort,
  output logic                   busy,
  output logic                   load_done,
  output logic                   abort_done,
  output logic                   dma_cmd_valid,
  input  logic                   dma_cmd_ready,
  output logic [DDR_AW-1:0]      dma_cmd_addr,
  output logic [MEM_AW-1:0]      dma_cmd_num,
  output logic [MEM_AW-1:0]      ibuf_base_addr,
  input  logic                   dma_write_done,
  output logic [1:0]             bank_valid,
  output logic [1:0]             bank_last,
  output logic [2*MEM_AW-1:0]    bank_beats,
  input  logic [1:0]             fetch_bank_rel,
  output logic [2:0]             dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_BANK = 3'd1,
    S_ISSUE     = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_FINISH    = 3'd4
  } state_t;

  localparam logic [LEN_W-1:0]  DEPTH_L = LEN_W'(BANK_DEPTH);
  localparam logic [MEM_AW-1:0] DEPTH_M = MEM_AW'(BANK_DEPTH);
  localparam logic [DDR_AW-1:0] BEAT_A  = DDR_AW'(BEAT_BYTES);

  state_t                   state_q, state_d;
  logic [DDR_AW-1:0]        addr_q, addr_d;
  logic [LEN_W-1:0]         remaining_q, remaining_d;
  logic                     cur_bank_q, cur_bank_d;
  logic                     abort_pend_q, abort_pend_d;
  logic                     abort_done_q, abort_done_d;
  logic [1:0]               bank_valid_q, bank_valid_d;
  logic [1:0]               bank_last_q, bank_last_d;
  logic [1:0][MEM_AW-1:0]   beats_q, beats_d;

  logic [LEN_W-1:0]         chunk;
  logic                     bank_free;
  logic                     abort_now;

  assign chunk     = (remaining_q < DEPTH_L) ? remaining_q : DEPTH_L;
  // A release arriving in the same cycle already frees the bank.
  assign bank_free = !bank_valid_q[cur_bank_q] || fetch_bank_rel[cur_bank_q];
  assign abort_now = abort_pend_q || cfg_abort;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      remaining_q  <= '0;
      cur_bank_q   <= 1'b0;
      abort_pend_q <= 1'b0;
      abort_done_q <= 1'b0;
      bank_valid_q <= '0;
      bank_last_q  <= '0;
      beats_q      <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      remaining_q  <= remaining_d;
      cur_bank_q   <= cur_bank_d;
      abort_pend_q <= abort_pend_d;
      abort_done_q <= abort_done_d;
      bank_valid_q <= bank_valid_d;
      bank_last_q  <= bank_last_d;
      beats_q      <= beats_d;
    end
  end

  // DMA command handshake: dma_cmd_valid is high for the whole ISSUE state and the
  // command fields are held constant; the transfer happens on the first rising edge
  // with dma_cmd_valid && dma_cmd_ready, and valid drops in the following cycle.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    remaining_d  = remaining_q;
    cur_bank_d   = cur_bank_q;
    abort_pend_d = abort_pend_q;
    abort_done_d = 1'b0;
    bank_valid_d = bank_valid_q & ~fetch_bank_rel;
    bank_last_d  = bank_last_q & ~fetch_bank_rel;
    beats_d      = beats_q;

    unique case (state_q)
      S_IDLE: begin
        if (cfg_start) begin
          if (cfg_total_beats == '0) begin
            state_d = S_FINISH;
          end else begin
            addr_d       = cfg_base_addr;
            remaining_d  = cfg_total_beats;
            cur_bank_d   = 1'b0;
            abort_pend_d = 1'b0;
            state_d      = S_WAIT_BANK;
          end
        end
      end
      S_WAIT_BANK: begin
        if (cfg_abort) begin
          abort_done_d = 1'b1;
          state_d      = S_IDLE;
        end else if (bank_free) begin
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (dma_cmd_ready) begin
          // The command is already accepted, so an abort must wait for its data.
          abort_pend_d = cfg_abort;
          state_d      = S_WAIT_DONE;
        end else if (cfg_abort) begin
          abort_done_d = 1'b1;
          state_d      = S_IDLE;
        end
      end
      S_WAIT_DONE: begin
        if (cfg_abort) abort_pend_d = 1'b1;
        if (dma_write_done) begin
          if (abort_now) begin
            abort_pend_d = 1'b0;
            abort_done_d = 1'b1;
            state_d      = S_IDLE;
          end else begin
            bank_valid_d[cur_bank_q] = 1'b1;
            beats_d[cur_bank_q]      = MEM_AW'(chunk);
            addr_d                   = addr_q + DDR_AW'(chunk) * BEAT_A;
            remaining_d              = remaining_q - chunk;
            cur_bank_d               = ~cur_bank_q;
            if (remaining_q == chunk) begin
              bank_last_d[cur_bank_q] = 1'b1;
              state_d                 = S_FINISH;
            end else begin
              state_d = S_WAIT_BANK;
            end
          end
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy           = (state_q != S_IDLE);
  assign load_done      = (state_q == S_FINISH);
  assign abort_done     = abort_done_q;
  assign dma_cmd_valid  = (state_q == S_ISSUE);
  assign dma_cmd_addr   = addr_q;
  assign dma_cmd_num    = MEM_AW'(chunk);
  assign ibuf_base_addr = cur_bank_q ? DEPTH_M : '0;
  assign bank_valid     = bank_valid_q;
  assign bank_last      = bank_last_q;
  assign bank_beats     = beats_q;
  assign dbg_state      = state_q;

endmodule

// File: doc/ictrl_ibuffer_load_sched.md
Name: ictrl_ibuffer_load_sched

Overview:
Scheduler that loads a program image from external memory into the instruction buffer (ibuffer) through the DMA-read-to-ibuffer write path. The ibuffer is used as two ping-pong banks. The block splits a load request into per-bank chunks, issues one DMA read command per chunk, waits for the writer's completion pulse, and hands filled banks to the instruction fetch unit. It sits between the ictrl config registers, the DMA read engine/ibuffer writer, and the fetch unit.

Parameters:
MEM_AW, 15, ibuffer address width and width of the per-chunk beat count
DDR_AW, 32, external byte-address width
LEN_W, 20, width of the total-beat count
BANK_DEPTH, 256, beats per ibuffer bank; power of 2, at most 2^(MEM_AW-1)
BEAT_BYTES, 16, bytes per DMA beat (DATA_WIDTH/8)

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
cfg_start  in  1  single-cycle load request
cfg_base_addr  in  DDR_AW  program byte address, BEAT_BYTES-aligned; sampled on accepted start
cfg_total_beats  in  LEN_W  total beats to load; sampled on accepted start
cfg_abort  in  1  single-cycle abort request
busy  out  1  high whenever the state is not IDLE
load_done  out  1  one-cycle pulse when the last chunk has been written
abort_done  out  1  one-cycle pulse when an abort completes
dma_cmd_valid  out  1  DMA read command valid
dma_cmd_ready  in  1  DMA engine accepts the command
dma_cmd_addr  out  DDR_AW  chunk source byte address
dma_cmd_num  out  MEM_AW  chunk beat count; drives the writer's dma_rd_data_num
ibuf_base_addr  out  MEM_AW  ibuffer base address of the target bank (bank*BANK_DEPTH)
dma_write_done  in  1  writer pulse: last beat of the current chunk is written into the ibuffer
bank_valid  out  2  bank b holds fetchable code
bank_last  out  2  bank b holds the final chunk of the program
bank_beats  out  2*MEM_AW  valid beat count per bank; bank 1 in the upper field
fetch_bank_rel  in  2  one-hot pulse: fetch unit releases a bank

Behaviour:
- Reset: state=IDLE. All outputs are 0: busy, load_done, abort_done, dma_cmd_valid, dma_cmd_addr, dma_cmd_num, ibuf_base_addr, bank_valid, bank_last, bank_beats. Internal values also reset: remaining=0, cur_bank=0, abort_pend=0. Reset mid-load drops everything; any DMA transfer still in flight is the system's responsibility.
- States: IDLE, WAIT_BANK, ISSUE, WAIT_DONE, FINISH.
- IDLE:
  - cfg_start with cfg_total_beats==0 -> FINISH; no command is issued.
  - cfg_start otherwise -> latch addr and remaining, set cur_bank=0, go to WAIT_BANK.
  - cfg_start in any non-IDLE state is ignored.
- WAIT_BANK:
  - chunk = min(remaining, BANK_DEPTH).
  - If bank_valid[cur_bank]==0 -> ISSUE, driving dma_cmd_valid=1 from the next cycle.
  - A release arriving in the same cycle counts as free, so WAIT_BANK lasts at least 1 cycle.
- ISSUE:
  - dma_cmd_valid=1. dma_cmd_addr, dma_cmd_num=chunk and ibuf_base_addr stay stable until dma_cmd_ready.
  - On the handshake -> WAIT_DONE; dma_cmd_valid drops the next cycle.
- WAIT_DONE, on dma_write_done:
  - Set bank_valid[cur_bank] and bank_beats[cur_bank]=chunk.
  - addr += chunk*BEAT_BYTES (modulo 2^DDR_AW); remaining -= chunk; cur_bank toggles.
  - If remaining becomes 0: set bank_last[old bank] and go to FINISH. Otherwise go to WAIT_BANK.
  - A dma_write_done pulse outside WAIT_DONE is ignored.
- FINISH: load_done=1 for 1 cycle -> IDLE.
- fetch_bank_rel[b], any state: clears bank_valid[b] and bank_last[b]. A release of a bank that is not valid is ignored. Set and release of different banks in the same cycle are both applied.
- Abort:
  - In WAIT_BANK or ISSUE before the handshake: drop dma_cmd_valid, pulse abort_done, go to IDLE.
  - In WAIT_DONE: set abort_pend. On dma_write_done, do not set bank_valid, pulse abort_done, go to IDLE.
  - Abort never pulses load_done. Banks that are already valid keep their state until released.
  - Abort in IDLE or FINISH is ignored.
- Arithmetic: the chunk comparison is done at LEN_W width; dma_cmd_num is the low MEM_AW bits (chunk <= BANK_DEPTH always fits).

Test Plan:
- Base 0x1000, total 100 -> one command: addr 0x1000, num 100, ibuf_base 0. After write_done: bank_valid=01, bank_beats[0]=100, bank_last=01, then load_done 1 cycle later.
- Total 600, no releases -> commands are (0x1000,256,base 0) and (0x2000,256,base 256). The third stalls in WAIT_BANK. Release bank0 -> command (0x3000,88,base 0); load_done; bank_last=01.
- Total 0 -> load_done 1 cycle after start; no dma_cmd_valid; busy high for 1 cycle.
- dma_cmd_ready held low 5 cycles -> command fields stable for all 6 valid cycles; exactly one handshake.
- Abort during WAIT_DONE of chunk 1 of 2 -> no bank set; abort_done on the write_done cycle +1; no load_done; a new start is then accepted normally.
- Second cfg_start while busy, and fetch_bank_rel=10 when bank1 is invalid -> both ignored; the load sequence is unchanged.
